// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage of the 8-bit processor.
//
// Holds the program counter, reads one word per fetch from synchronous program
// memory (data valid the cycle after pm_rd), classifies the opcode and presents
// the instruction plus decoded fields to the execute stage over valid/ready.
// Branch redirects discard any in-flight or held instruction; HALT is sticky
// until reset.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pm_addr, pm_rd        program memory address / read strobe
//   pm_data               program memory read data
//   instruction           captured instruction word
//   opcode, rd, rs, imm   slices of instruction
//   instr_valid           instruction offered to the execute stage
//   instr_ready           execute stage accepts this cycle
//   branch_en/addr        redirect request and target
//   illegal_op            one-cycle pulse when an undefined opcode is dropped
//   halted                HALT reached
module fetch_decode #(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd,
  input  logic [7:0]        pm_data,
  output logic [7:0]        instruction,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [3:0]        imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              illegal_op,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StIssue,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic              pm_rd_q, valid_q, illegal_q, halted_q;
  logic              illegal_d;

  // Opcode classification of the word arriving from program memory.
  logic op_legal, op_halt;

  always_comb begin
    op_legal = 1'b0;
    op_halt  = 1'b0;
    unique case (pm_data[7:4])
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b1100: op_legal = 1'b1;
      4'b1111:                                     op_halt  = 1'b1;
      default:                                     ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (branch_en) pc_d = branch_addr;
      end
      StFetch: begin
        if (branch_en) begin
          pc_d    = branch_addr;
          state_d = StFetch;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (branch_en) begin
          // Redirect wins: the arriving word is dropped without side effects.
          pc_d    = branch_addr;
          state_d = StFetch;
        end else begin
          instr_d = pm_data;
          pc_d    = pc_q + ADDR_W'(1);
          if (op_halt) begin
            state_d = StHalt;
          end else if (op_legal) begin
            state_d = StIssue;
          end else begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        end
      end
      StIssue: begin
        // A branch alongside instr_ready still counts as an accept; either way
        // the held instruction is retired and fetch restarts.
        if (branch_en) begin
          pc_d    = branch_addr;
          state_d = StFetch;
        end else if (instr_ready) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 8'h00;
      pm_rd_q   <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pm_rd_q   <= (state_d == StFetch);
      valid_q   <= (state_d == StIssue);
      illegal_q <= illegal_d;
      halted_q  <= (state_d == StHalt);
    end
  end

  assign pm_addr     = pc_q;
  assign pm_rd       = pm_rd_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[7:4];
  assign rd          = instr_q[3:2];
  assign rs          = instr_q[1:0];
  assign imm         = instr_q[3:0];
  assign instr_valid = valid_q;
  assign illegal_op  = illegal_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pm_addr;
  logic       pm_rd;
  logic [7:0] pm_data = 8'h00;
  logic [7:0] instruction;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] imm;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_addr = 8'h00;
  logic       illegal_op;
  logic       halted;

  fetch_decode #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pm_addr     (pm_addr),
    .pm_rd       (pm_rd),
    .pm_data     (pm_data),
    .instruction (instruction),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .illegal_op  (illegal_op),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data one cycle after the read strobe.
  logic [7:0] mem [256];
  always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

  typedef struct packed {
    logic [7:0] ins;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ill_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] ins, input logic [3:0] op,
                              input logic [1:0] r_d, input logic [1:0] r_s,
                              input logic [3:0] im);
    exp_t e;
    e.ins = ins; e.op = op; e.rd = r_d; e.rs = r_s; e.imm = im;
    return e;
  endfunction

  // Monitor: every accepted instruction is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got 0x%0h expected none", instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue", {12'h0, instruction, opcode, rd, rs, imm}, {12'h0, e});
      end
    end
    if (!reset && illegal_op) ill_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  // sel: 0 instr_valid, 1 halted, 2 illegal_op, 3 pm_rd
  task automatic wait_for(input int sel, input string nm);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      case (sel)
        0: hit = instr_valid;
        1: hit = halted;
        2: hit = illegal_op;
        default: hit = pm_rd;
      endcase
      if (hit) break;
      tick();
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got no event expected event within 60 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic issue stream with ready held high.
    fill_halt();
    mem[8'h00] = 8'h4E;
    mem[8'h01] = 8'hC7;
    instr_ready = 1'b1;
    do_reset();
    chk("reset_outs", {pm_addr, pm_rd, instruction, instr_valid, illegal_op, halted},
        {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("reset_fields", {opcode, rd, rs, imm}, 12'h000);
    exp_q.push_back(mk(8'h4E, 4'h4, 2'd3, 2'd2, 4'hE));
    exp_q.push_back(mk(8'hC7, 4'hC, 2'd1, 2'd3, 4'h7));
    acc_q.delete();
    tick();
    chk("first_fetch", {pm_rd, pm_addr}, {1'b1, 8'h00});
    wait_for(1, "halt1");
    chk("issue_count", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("issue_spacing", acc_q[1] - acc_q[0], 3);
    chk("halt_outs", {pm_rd, instr_valid, illegal_op, halted, pm_addr},
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h03});
    branch_en   = 1'b1;
    branch_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_ignores_branch", {pm_rd, instr_valid, halted, pm_addr},
          {1'b0, 1'b0, 1'b1, 8'h03});
    end
    branch_en = 1'b0;
    do_reset();
    chk("reset_after_halt", {pm_addr, halted, pm_rd}, {8'h00, 1'b0, 1'b0});
    chk("q_empty_1", exp_q.size(), 0);

    // Backpressure followed by an illegal word at 0x02.
    fill_halt();
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h30;
    mem[8'h02] = 8'h25;
    mem[8'h03] = 8'h11;
    instr_ready = 1'b0;
    do_reset();
    ill_cnt = 0;
    exp_q.push_back(mk(8'h01, 4'h0, 2'd0, 2'd1, 4'h1));
    exp_q.push_back(mk(8'h30, 4'h3, 2'd0, 2'd0, 4'h0));
    exp_q.push_back(mk(8'h11, 4'h1, 2'd0, 2'd1, 4'h1));
    wait_for(0, "valid_bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("backpressure_hold", {instr_valid, instruction, pm_rd}, {1'b1, 8'h01, 1'b0});
    end
    instr_ready = 1'b1;
    tick();
    chk("release_refetch", {instr_valid, pm_rd, pm_addr}, {1'b0, 1'b1, 8'h01});
    wait_for(2, "illegal");
    chk("illegal_next_fetch", {instr_valid, pm_rd, pm_addr}, {1'b0, 1'b1, 8'h03});
    tick();
    chk("illegal_one_cycle", illegal_op, 1'b0);
    wait_for(1, "halt2");
    chk("illegal_count", ill_cnt, 1);
    chk("q_empty_2", exp_q.size(), 0);

    // Branch during WAIT suppresses the in-flight (illegal) word.
    fill_halt();
    mem[8'h00] = 8'h25;
    mem[8'h40] = 8'h4E;
    do_reset();
    ill_cnt = 0;
    exp_q.push_back(mk(8'h4E, 4'h4, 2'd3, 2'd2, 4'hE));
    tick();
    chk("br_fetch0", {pm_rd, pm_addr}, {1'b1, 8'h00});
    tick();
    chk("br_wait_state", {pm_rd, instr_valid}, {1'b0, 1'b0});
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    tick();
    branch_en = 1'b0;
    chk("br_redirect", {pm_rd, pm_addr, illegal_op, instr_valid}, {1'b1, 8'h40, 1'b0, 1'b0});
    wait_for(1, "halt3");
    chk("br_no_illegal", ill_cnt, 0);
    chk("br_pc_after_halt", pm_addr, 8'h42);
    chk("q_empty_3", exp_q.size(), 0);

    // pc wrap from 0xFF to 0x00.
    fill_halt();
    mem[8'hFF] = 8'h30;
    mem[8'h00] = 8'hF0;
    do_reset();
    branch_en   = 1'b1;
    branch_addr = 8'hFF;
    tick();
    branch_en = 1'b0;
    chk("wrap_fetch_ff", {pm_rd, pm_addr}, {1'b1, 8'hFF});
    exp_q.push_back(mk(8'h30, 4'h3, 2'd0, 2'd0, 4'h0));
    wait_for(0, "valid_wrap");
    tick();
    chk("wrap_fetch_00", {pm_rd, pm_addr}, {1'b1, 8'h00});
    wait_for(1, "halt4");
    chk("q_empty_4", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage of the 8-bit processor, directly upstream of `main`. It holds the program counter, reads one instruction per fetch from synchronous program memory, classifies the opcode, and presents the instruction plus its decoded fields to `main` over a valid/ready handshake. It also services branch redirects from the execute side and stops permanently on HALT.

## Interface
- `ADDR_W`, default 8: program counter and program-memory address width.
- `RESET_PC`, default 8'h00: program counter value after reset.
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pm_addr`  out  ADDR_W  program memory address.
- `pm_rd`  out  1  program memory read strobe.
- `pm_data`  in  8  program memory read data, valid the cycle after `pm_rd`.
- `instruction`  out  8  captured instruction word.
- `opcode`  out  4  `instruction[7:4]`.
- `rd`  out  2  `instruction[3:2]`.
- `rs`  out  2  `instruction[1:0]`.
- `imm`  out  4  `instruction[3:0]`, the SMI immediate.
- `instr_valid`  out  1  instruction and fields valid for `main`.
- `instr_ready`  in  1  `main` accepts the instruction this cycle.
- `branch_en`  in  1  redirect request.
- `branch_addr`  in  ADDR_W  redirect target.
- `illegal_op`  out  1  one-cycle pulse: an undefined opcode was dropped.
- `halted`  out  1  HALT reached; sticky until reset.

## Operation
- Legal opcodes: LD 0000, ST 0001, MR 0011, SUM 0100, SMI 1100, HALT 1111. All other opcodes are illegal.
- FSM states: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE lasts one cycle after reset, then goes to FETCH.
- FETCH: `pm_rd`=1 and `pm_addr`=pc. Next state is WAIT.
- WAIT: `pm_data` is valid. At the end of the cycle it is captured into `instruction`, and pc <= pc+1 with a modulo-2^ADDR_W wrap (0xFF -> 0x00).
  - Captured opcode legal and not HALT: go to ISSUE.
  - Captured HALT: go to HALT. The instruction is not issued.
  - Captured illegal opcode: `illegal_op` pulses high for the next cycle, the instruction is not issued, and the FSM goes to FETCH.
- ISSUE: `instr_valid`=1, and `instruction` and all fields are held stable. When `instr_valid && instr_ready` is sampled, `instr_valid` drops next cycle and the FSM goes to FETCH.
- HALT: `halted`=1, and `pm_rd`, `instr_valid`, `illegal_op` are all 0. Only `reset` exits this state.
- Branch: `branch_en` sampled high in IDLE, FETCH, WAIT or ISSUE sets pc <= `branch_addr`. The FSM then goes to FETCH, and any fetched or held instruction is discarded.
  - A WAIT-cycle capture that coincides with a branch is suppressed: no issue, no `illegal_op`, no HALT, no pc increment.
  - In ISSUE, a branch coinciding with `instr_ready`=1 counts as an accepted instruction. `instr_valid` still drops next cycle.
- `branch_en` is ignored in HALT.
- Reset has priority over everything, including mid-fetch and mid-handshake.
- Decoded fields are pure slices of the registered `instruction`. They carry no extra latency.

## Timing
- Reset values: pc=`RESET_PC`, `pm_addr`=`RESET_PC`, `pm_rd`=0, `instruction`=8'h00 (fields 0), `instr_valid`=0, `illegal_op`=0, `halted`=0, state IDLE.
- All outputs are registered.
- Latency from the FETCH cycle to the first cycle of `instr_valid` is 2 cycles.
- Best-case throughput is one instruction per 3 cycles, reached when `instr_ready` is held at 1.
- Backpressure: while `instr_ready`=0, `instr_valid` stays 1, outputs hold, and no new fetch starts.
- Redirect penalty: the first FETCH of `branch_addr` happens the cycle after `branch_en` is sampled.
- HALT: `halted` rises the cycle after the HALT word is captured.

## Test plan
- Reset, program memory {0x00:8'h4E, 0x01:8'hC7}, `instr_ready`=1:
  - `pm_addr`=0x00 in the first FETCH cycle.
  - 8'h4E issues with `opcode`=4, `rd`=3, `rs`=2.
  - 8'hC7 issues next with `imm`=7.
  - Issues are 3 cycles apart.
- Backpressure: hold `instr_ready`=0 for 5 cycles on 8'h01 -> `instr_valid` stays 1, `instruction` stays stable, `pm_rd` stays 0. Releasing `instr_ready` produces one accept followed by the next fetch.
- Illegal word 8'h25 at 0x02 -> `illegal_op` pulses once, no `instr_valid`, and the next fetch is at `pm_addr`=0x03.
- Branch during WAIT to 0x40 -> the in-flight word is neither issued nor flagged, the next FETCH has `pm_addr`=0x40, and no pc increment occurs.
- pc=0xFF holding 8'h30 -> the word issues and the next `pm_addr` is 0x00.
- HALT word 8'hF0 -> `halted`=1 and no further `pm_rd`. `branch_en` is then ignored. `reset` returns to `pm_addr`=0x00 with `halted`=0.
